// File: rtl/ama_riscv_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and load/store.
// LS wins by default; IF is forced through after STARVE_MAX consecutive denials.
module ama_riscv_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // fetch side
  input  logic            if_req_valid,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_req_ready,
  input  logic            if_flush,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  // load/store side
  input  logic            ls_req_valid,
  input  logic            ls_req_we,
  input  logic [DW/8-1:0] ls_req_wstrb,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic [DW-1:0]   ls_req_wdata,
  output logic            ls_req_ready,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rsp_data,
  // memory side
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef struct packed {
    logic valid;
    logic owner_ls;
  } tag_t;

  logic             grant_if, grant_ls;
  logic [3:0]       starve_q, starve_d;
  tag_t             push_tag, out_tag;
  tag_t [LAT-1:0]   pipe_q, pipe_d;

  // Grants are forced low while reset is held so no request is accepted.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (rst) begin
      if (starve_q == 4'(STARVE_MAX) && if_req_valid) grant_if = 1'b1;
      else if (ls_req_valid)                          grant_ls = 1'b1;
      else if (if_req_valid)                          grant_if = 1'b1;
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  assign mem_en    = grant_if | grant_ls;
  assign mem_addr  = grant_ls ? ls_req_addr : if_req_addr;
  assign mem_wdata = grant_ls ? ls_req_wdata : '0;
  assign mem_we    = (grant_ls && ls_req_we) ? ls_req_wstrb : '0;

  always_comb begin
    starve_d = starve_q;
    if (!if_req_valid || grant_if) begin
      starve_d = 4'd0;
    end else if (starve_q < 4'(STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign push_tag.valid    = grant_if | (grant_ls & ~ls_req_we);
  assign push_tag.owner_ls = grant_ls;

  // A fetch pushed in the flush cycle is the redirected one and must survive.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = push_tag;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (if_flush && !pipe_q[i-1].owner_ls) pipe_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
      pipe_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pipe_q   <= pipe_d;
    end
  end

  assign out_tag      = pipe_q[LAT-1];
  assign if_rsp_valid = out_tag.valid & ~out_tag.owner_ls & ~if_flush;
  assign ls_rsp_valid = out_tag.valid & out_tag.owner_ls;
  assign if_rsp_data  = mem_rdata;
  assign ls_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Scoreboard bench for ama_riscv_mem_arbiter: one LAT=1 instance for arbitration/store/reset
// and one LAT=3 instance for fetch flush; each has its own behavioural memory.
module tb_ama_riscv_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_if1[$], q_ls1[$], q_if3[$], q_ls3[$];

  // LAT=1 instance signals
  logic        d1_if_valid = 0, d1_if_ready, d1_if_flush = 0, d1_if_rsp_valid;
  logic [31:0] d1_if_addr = 0, d1_if_rsp_data;
  logic        d1_ls_valid = 0, d1_ls_we = 0, d1_ls_ready, d1_ls_rsp_valid;
  logic [3:0]  d1_ls_wstrb = 0, d1_mem_we;
  logic [31:0] d1_ls_addr = 0, d1_ls_wdata = 0, d1_ls_rsp_data;
  logic        d1_mem_en;
  logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

  // LAT=3 instance signals
  logic        d3_if_valid = 0, d3_if_ready, d3_if_flush = 0, d3_if_rsp_valid;
  logic [31:0] d3_if_addr = 0, d3_if_rsp_data;
  logic        d3_ls_valid = 0, d3_ls_we = 0, d3_ls_ready, d3_ls_rsp_valid;
  logic [3:0]  d3_ls_wstrb = 0, d3_mem_we;
  logic [31:0] d3_ls_addr = 0, d3_ls_wdata = 0, d3_ls_rsp_data;
  logic        d3_mem_en;
  logic [31:0] d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

  ama_riscv_mem_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(d1_if_valid), .if_req_addr(d1_if_addr), .if_req_ready(d1_if_ready),
    .if_flush(d1_if_flush), .if_rsp_valid(d1_if_rsp_valid), .if_rsp_data(d1_if_rsp_data),
    .ls_req_valid(d1_ls_valid), .ls_req_we(d1_ls_we), .ls_req_wstrb(d1_ls_wstrb),
    .ls_req_addr(d1_ls_addr), .ls_req_wdata(d1_ls_wdata), .ls_req_ready(d1_ls_ready),
    .ls_rsp_valid(d1_ls_rsp_valid), .ls_rsp_data(d1_ls_rsp_data),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
  );

  ama_riscv_mem_arbiter #(.AW(32), .DW(32), .LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(d3_if_valid), .if_req_addr(d3_if_addr), .if_req_ready(d3_if_ready),
    .if_flush(d3_if_flush), .if_rsp_valid(d3_if_rsp_valid), .if_rsp_data(d3_if_rsp_data),
    .ls_req_valid(d3_ls_valid), .ls_req_we(d3_ls_we), .ls_req_wstrb(d3_ls_wstrb),
    .ls_req_addr(d3_ls_addr), .ls_req_wdata(d3_ls_wdata), .ls_req_ready(d3_ls_ready),
    .ls_rsp_valid(d3_ls_rsp_valid), .ls_rsp_data(d3_ls_rsp_data),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
    .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata)
  );

  // Behavioural memories: word i initialised to 0xC0DE0000 | byte address.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hC0DE_0000 | (32'(i) << 2);
      mem3[i] = 32'hC0DE_0000 | (32'(i) << 2);
    end
  end

  always @(posedge clk) begin
    if (d1_mem_en) begin
      rd1 <= mem1[d1_mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (d1_mem_we[b]) mem1[d1_mem_addr[9:2]][8*b +: 8] <= d1_mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (d3_mem_en) rd3[0] <= mem3[d3_mem_addr[9:2]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign d1_mem_rdata = rd1;
  assign d3_mem_rdata = rd3[2];

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    return 32'hC0DE_0000 | addr;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    if (rst) begin
      if (d1_if_valid) assert (d1_if_addr[1:0] == 2'b00) else $error("misaligned fetch");
      if (d1_if_rsp_valid) begin
        if (q_if1.size() == 0) chk("if1_unexpected_rsp", 32'd1, 32'd0);
        else chk("if1_rsp_data", d1_if_rsp_data, q_if1.pop_front());
      end
      if (d1_ls_rsp_valid) begin
        if (q_ls1.size() == 0) chk("ls1_unexpected_rsp", 32'd1, 32'd0);
        else chk("ls1_rsp_data", d1_ls_rsp_data, q_ls1.pop_front());
      end
      if (d3_if_rsp_valid) begin
        if (q_if3.size() == 0) chk("if3_unexpected_rsp", 32'd1, 32'd0);
        else chk("if3_rsp_data", d3_if_rsp_data, q_if3.pop_front());
      end
      if (d3_ls_rsp_valid) begin
        if (q_ls3.size() == 0) chk("ls3_unexpected_rsp", 32'd1, 32'd0);
        else chk("ls3_rsp_data", d3_ls_rsp_data, q_ls3.pop_front());
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_d1_if_ready"}, 32'(d1_if_ready), 32'd0);
    chk({tag, "_d1_ls_ready"}, 32'(d1_ls_ready), 32'd0);
    chk({tag, "_d1_mem_en"}, 32'(d1_mem_en), 32'd0);
    chk({tag, "_d1_mem_we"}, 32'(d1_mem_we), 32'd0);
    chk({tag, "_d1_if_rsp_valid"}, 32'(d1_if_rsp_valid), 32'd0);
    chk({tag, "_d1_ls_rsp_valid"}, 32'(d1_ls_rsp_valid), 32'd0);
    chk({tag, "_d3_if_ready"}, 32'(d3_if_ready), 32'd0);
    chk({tag, "_d3_mem_en"}, 32'(d3_mem_en), 32'd0);
    chk({tag, "_d3_if_rsp_valid"}, 32'(d3_if_rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] la;

    // Reset state, with requests already pending
    #2;
    d1_if_valid = 1; d1_ls_valid = 1; d3_if_valid = 1;
    #1;
    chk_outputs_zero("reset");
    chk("reset_starve_cnt", 32'(u_dut1.starve_q), 32'd0);
    d1_if_valid = 0; d1_ls_valid = 0; d3_if_valid = 0;
    idle(2);
    rst = 1;
    idle(1);

    // IF-only stream, three beats back to back
    for (int i = 0; i < 3; i++) begin
      d1_if_valid = 1; d1_if_addr = 32'(4 * i);
      q_if1.push_back(init_word(32'(4 * i)));
      #3 chk("if_stream_ready", 32'(d1_if_ready), 32'd1);
      step();
    end
    d1_if_valid = 0;
    idle(3);

    // IF and LS collide: LS load first, IF the next cycle
    d1_if_valid = 1; d1_if_addr = 32'h40; q_if1.push_back(init_word(32'h40));
    d1_ls_valid = 1; d1_ls_we = 0; d1_ls_addr = 32'h100; q_ls1.push_back(init_word(32'h100));
    #3;
    chk("collide_ls_ready", 32'(d1_ls_ready), 32'd1);
    chk("collide_if_ready", 32'(d1_if_ready), 32'd0);
    chk("collide_mem_addr", d1_mem_addr, 32'h100);
    chk("collide_mem_en", 32'(d1_mem_en), 32'd1);
    step();
    d1_ls_valid = 0;
    #3;
    chk("collide_if_next_ready", 32'(d1_if_ready), 32'd1);
    chk("collide_if_mem_addr", d1_mem_addr, 32'h40);
    step();
    d1_if_valid = 0;
    idle(3);

    // Starvation: IF forced through on the 5th cycle of continuous LS traffic
    d1_if_valid = 1; d1_if_addr = 32'h80; q_if1.push_back(init_word(32'h80));
    la = 32'h300;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        d1_if_valid = 0;
        chk("starve_cnt_cleared", 32'(u_dut1.starve_q), 32'd0);
      end
      d1_ls_valid = 1; d1_ls_we = 0; d1_ls_addr = la;
      #3;
      chk("starve_if_ready", 32'(d1_if_ready), (c == 4) ? 32'd1 : 32'd0);
      chk("starve_ls_ready", 32'(d1_ls_ready), (c == 4) ? 32'd0 : 32'd1);
      if (d1_ls_ready) begin
        q_ls1.push_back(init_word(la));
        la = la + 32'd4;
      end
      step();
    end
    d1_ls_valid = 0;
    idle(3);

    // Partial store then readback
    d1_ls_valid = 1; d1_ls_we = 1; d1_ls_wstrb = 4'b0011;
    d1_ls_addr = 32'h200; d1_ls_wdata = 32'h1122_3344;
    #3;
    chk("store_ready", 32'(d1_ls_ready), 32'd1);
    chk("store_mem_we", 32'(d1_mem_we), 32'h3);
    chk("store_mem_wdata", d1_mem_wdata, 32'h1122_3344);
    step();
    d1_ls_we = 0; d1_ls_wstrb = 0;
    q_ls1.push_back(32'hC0DE_3344);
    #3;
    chk("load_mem_we", 32'(d1_mem_we), 32'd0);
    step();
    d1_ls_valid = 0;
    idle(3);

    // LAT=3 flush: three fetches in flight are killed, the redirected one survives
    for (int i = 0; i < 3; i++) begin
      d3_if_valid = 1; d3_if_addr = 32'h10 + 32'(4 * i);
      #3 chk("flush_old_ready", 32'(d3_if_ready), 32'd1);
      step();
    end
    d3_if_addr = 32'h1C; d3_if_flush = 1; q_if3.push_back(init_word(32'h1C));
    #3;
    chk("flush_new_ready", 32'(d3_if_ready), 32'd1);
    chk("flush_out_stage_killed", 32'(d3_if_rsp_valid), 32'd0);
    step();
    d3_if_valid = 0; d3_if_flush = 0;
    idle(6);

    // Reset mid-stream with a load in flight
    d1_ls_valid = 1; d1_ls_we = 0; d1_ls_addr = 32'h104;
    step();
    d1_if_valid = 1; d1_if_addr = 32'h8; d3_if_valid = 1;
    #1 rst = 0;
    #1 chk_outputs_zero("midrst");
    d1_ls_valid = 0; d1_if_valid = 0; d3_if_valid = 0;
    idle(2);
    rst = 1;
    idle(5);

    chk("q_if1_drained", 32'(q_if1.size()), 32'd0);
    chk("q_ls1_drained", 32'(q_ls1.size()), 32'd0);
    chk("q_if3_drained", 32'(q_if3.size()), 32'd0);
    chk("q_ls3_drained", 32'(q_ls3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
